imem_loader: RTL and testbench

Instruction-memory loader: the writer side of the instruction memory that the processor only reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into the imem write port starting at address 0. While a load is in progress it holds the processor in reset, so a new program image can be installed without a resynthesis.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_word_assembler.sv | 50 +++++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN (see imem_loader.sv) adds a trailing XOR checksum byte to the frame.
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int FRAME_LEN_BYTES    = 2;
  localparam int BYTES_PER_WORD     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  // Running payload checksum: plain byte-wise XOR.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: shifts stream bytes into a big-endian 32-bit word and flags it once complete.
// word_valid stays high from the 4th byte until the FSM consumes the word or a new session clears it.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        consume,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_complete
);

  localparam int               CNT_W     = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      word_r;
  logic             valid_r;

  assign word_complete = byte_valid && (cnt_r == LAST_BYTE);
  assign word          = word_r;
  assign word_valid    = valid_r;

  // Byte counter, MSB-first shift register and the completed-word flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r   <= '0;
      word_r  <= 32'd0;
      valid_r <= 1'b0;
    end else if (clear) begin
      cnt_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      if (byte_valid) begin
        word_r <= {word_r[23:0], byte_data};
        cnt_r  <= cnt_r + CNT_W'(1);
      end
      if (word_complete) begin
        valid_r <= 1'b1;
      end else if (consume) begin
        valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte frame and writes it word by word into imem,
// holding the processor in reset meanwhile. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  output logic                  hold_cpu,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = ST_CSUM;
`else
  localparam state_t END_STATE = ST_DONE;
`endif

  state_t              state_r, state_s;
  logic [7:0]          len_hi_r;
  logic [15:0]         count_r, count_s;
  logic [ADDR_WIDTH:0] idx_r;
  logic                rx_ready_r, hold_cpu_r, busy_r, done_r, error_r;
  logic                xfer_s, start_ok_s, byte_valid_s, consume_s, last_word_s;
  logic                ready_s, hold_s, error_s;
  logic [31:0]         asm_word_s;
  logic                asm_valid_s, asm_complete_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_r;
`endif

  word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear        (start_ok_s),
    .byte_valid   (byte_valid_s),
    .byte_data    (rx_data),
    .consume      (consume_s),
    .word         (asm_word_s),
    .word_valid   (asm_valid_s),
    .word_complete(asm_complete_s)
  );

  // Next-state decode plus the values the output registers load on the next edge.
  always_comb begin
    xfer_s       = rx_valid && rx_ready_r;
    start_ok_s   = start && (state_r == ST_IDLE);
    byte_valid_s = xfer_s && (state_r == ST_DATA);
    consume_s    = (state_r == ST_WRITE);
    count_s      = {len_hi_r, rx_data};
    last_word_s  = ((17'(idx_r) + 17'd1) == {1'b0, count_r});
    state_s      = state_r;
    case (state_r)
      ST_IDLE:   if (start) state_s = ST_LEN_HI; else state_s = ST_IDLE;
      ST_LEN_HI: if (xfer_s) state_s = ST_LEN_LO; else state_s = ST_LEN_HI;
      ST_LEN_LO: begin
        if (!xfer_s) begin
          state_s = ST_LEN_LO;
        end else if (count_s == 16'd0) begin
          state_s = END_STATE;
        end else if ({1'b0, count_s} > MAX_WORDS) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DATA:   if (asm_complete_s) state_s = ST_WRITE; else state_s = ST_DATA;
      ST_WRITE:  if (last_word_s) state_s = END_STATE; else state_s = ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!xfer_s) begin
          state_s = ST_CSUM;
        end else if (rx_data == csum_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ERR;
        end
      end
`else
      ST_CSUM:   state_s = ST_IDLE;
`endif
      ST_DONE:   state_s = ST_IDLE;
      ST_ERR:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase

    ready_s = (state_s == ST_LEN_HI) || (state_s == ST_LEN_LO) ||
              (state_s == ST_DATA)   || (state_s == ST_CSUM);
    // hold_cpu drops only after a clean DONE; an ERR leaves it asserted.
    if (start_ok_s) begin
      hold_s = 1'b1;
    end else if (state_r == ST_DONE) begin
      hold_s = 1'b0;
    end else begin
      hold_s = hold_cpu_r;
    end
    if (start_ok_s) begin
      error_s = 1'b0;
    end else if (state_s == ST_ERR) begin
      error_s = 1'b1;
    end else begin
      error_s = error_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered status outputs, loaded from the upcoming state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_ready_r <= 1'b0;
      hold_cpu_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      rx_ready_r <= ready_s;
      hold_cpu_r <= hold_s;
      busy_r     <= (state_s != ST_IDLE) && (state_s != ST_ERR);
      done_r     <= (state_s == ST_DONE);
      error_r    <= error_s;
    end
  end

  // Frame length capture and the word index that addresses imem.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_hi_r <= 8'd0;
      count_r  <= 16'd0;
      idx_r    <= '0;
    end else begin
      if (xfer_s && (state_r == ST_LEN_HI)) len_hi_r <= rx_data;
      if (xfer_s && (state_r == ST_LEN_LO)) count_r <= count_s;
      if (start_ok_s) begin
        idx_r <= '0;
      end else if (state_r == ST_WRITE) begin
        idx_r <= idx_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Payload checksum accumulator; the length bytes are not included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_r <= 8'd0;
    end else if (start_ok_s) begin
      csum_r <= 8'd0;
    end else if (byte_valid_s) begin
      csum_r <= csum_update(csum_r, rx_data);
    end
  end
`endif

  assign rx_ready    = rx_ready_r;
  assign mem_address = idx_r[ADDR_WIDTH-1:0];
  assign mem_data    = asm_word_s;
  assign mem_wren    = asm_valid_s;
  assign hold_cpu    = hold_cpu_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: expected writes come from a word-list model of each frame,
// checked by a per-cycle monitor; latencies and end-of-session status are hand-derived.
module tb_imem_loader;

  localparam int AW = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  logic          clock, reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, mem_wren, hold_cpu, busy, done, error;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .hold_cpu(hold_cpu), .busy(busy), .done(done), .error(error)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  int wptr = 0, wren_cnt = 0, done_cnt = 0, hold_cnt = 0;
  int first_wren_cyc = 0, done_cyc = 0, sess = 0, seen_sess = 0;
  int snap_wren = 0, snap_done = 0, snap_hold = 0, start_cyc = 0;
  logic [31:0] exp_words[$];
  logic [7:0]  frame[$];
  int gap_tab[10] = '{3, 0, 5, 1, 2, 4, 0, 5, 3, 1};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write must be the next word of the image, at its own index, with rx_ready low.
  task automatic monitor();
    forever begin
      @(negedge clock);
      if (reset) begin
        if (sess != seen_sess) begin
          seen_sess = sess;
          wptr = 0;
        end
        if (mem_wren) begin
          if (wptr < exp_words.size()) begin
            check("wr_addr", 32'(mem_address), 32'(wptr));
            check("wr_data", mem_data, exp_words[wptr]);
          end else begin
            check("wr_beyond_image", 32'(wptr + 1), 32'(exp_words.size()));
          end
          check("wr_ready_low", 32'(rx_ready), 32'd0);
          if (wptr == 0) first_wren_cyc = cyc;
          wptr++;
          wren_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_no_error", 32'(error), 32'd0);
        end
        if (hold_cpu) hold_cnt++;
      end
    end
  endtask

  function automatic logic [7:0] payload_xor();
    logic [7:0] acc = 8'h00;
    foreach (exp_words[i]) acc ^= exp_words[i][31:24] ^ exp_words[i][23:16] ^
                                   exp_words[i][15:8]  ^ exp_words[i][7:0];
    return acc;
  endfunction

  task automatic make_frame(input logic [15:0] n_decl, input int add_csum, input logic [7:0] csum);
    frame.delete();
    frame.push_back(n_decl[15:8]);
    frame.push_back(n_decl[7:0]);
    foreach (exp_words[i])
      for (int k = 3; k >= 0; k--) frame.push_back(exp_words[i][8*k +: 8]);
    if (add_csum != 0) frame.push_back(csum);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
    int waited = 0;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      start    = poke_start && (g == 0);
      @(negedge clock);
      start = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gappy, input bit poke);
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], gappy ? gap_tab[i % 10] : 0, poke);
  endtask

  task automatic begin_session();
    sess++;
    snap_wren = wren_cnt;
    snap_done = done_cnt;
    snap_hold = hold_cnt;
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 25000) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
    @(negedge clock);
    #1;
  endtask

  task automatic check_end(input string tag, input int exp_wr, input int exp_done,
                           input logic exp_err, input logic exp_hold);
    check({tag, "_writes"}, 32'(wren_cnt - snap_wren), 32'(exp_wr));
    check({tag, "_done"}, 32'(done_cnt - snap_done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_hold"}, 32'(hold_cpu), 32'(exp_hold));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_data"}, mem_data, 32'd0);
    check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    check({tag, "_hold"}, 32'(hold_cpu), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clock);

    // Two-word load, no gaps: LEN_HI,LEN_LO,4xDATA puts the first write 7 cycles after start.
    exp_words = '{32'hDEADBEEF, 32'h01234567};
    make_frame(16'd2, CSUM_BYTES, payload_xor());
    begin_session();
    check("ready_after_start", 32'(rx_ready), 32'd1);
    check("hold_after_start", 32'(hold_cpu), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    send_frame(1'b0, 1'b0);
    wait_idle();
    check("first_wr_latency", 32'(first_wren_cyc - start_cyc), 32'd7);
    check("done_latency", 32'(done_cyc - start_cyc), 32'(13 + CSUM_BYTES));
    check_end("two_word", 2, 1, 1'b0, 1'b0);

    // Empty image: hold_cpu covers LEN_HI, LEN_LO, (CSUM,) DONE.
    exp_words = {};
    make_frame(16'd0, CSUM_BYTES, 8'h00);
    begin_session();
    send_frame(1'b0, 1'b0);
    wait_idle();
    check("empty_hold_cycles", 32'(hold_cnt - snap_hold), 32'(3 + CSUM_BYTES));
    check_end("empty", 0, 1, 1'b0, 1'b0);

    // Oversize count 0x1001 exceeds 4096 words.
    exp_words = {};
    make_frame(16'h1001, 0, 8'h00);
    begin_session();
    send_frame(1'b0, 1'b0);
    wait_idle();
    check_end("oversize", 0, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    check("oversize_hold_kept", 32'(hold_cpu), 32'd1);
    make_frame(16'd0, CSUM_BYTES, 8'h00);
    begin_session();
    check("error_cleared", 32'(error), 32'd0);
    send_frame(1'b0, 1'b0);
    wait_idle();
    check_end("after_err", 0, 1, 1'b0, 1'b0);

    // Backpressure with stray start pulses inside the gaps.
    exp_words = '{32'hDEADBEEF, 32'h01234567};
    make_frame(16'd2, CSUM_BYTES, payload_xor());
    begin_session();
    send_frame(1'b1, 1'b1);
    wait_idle();
    check_end("backpressure", 2, 1, 1'b0, 1'b0);

    // Reset after the 5th byte: nothing written, everything back to reset values at once.
    make_frame(16'd2, CSUM_BYTES, payload_xor());
    exp_words = {};
    begin_session();
    for (int i = 0; i < 5; i++) send_byte(frame[i], 0, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    exp_words = '{32'hDEADBEEF, 32'h01234567};
    begin_session();
    send_frame(1'b0, 1'b0);
    wait_idle();
    check_end("after_reset", 2, 1, 1'b0, 1'b0);

    // Exactly 4096 words: fills the whole memory, last write at 0xFFF.
    exp_words = {};
    for (int i = 0; i < 4096; i++) exp_words.push_back({16'(i) ^ 16'hC3A5, 16'(i)});
    make_frame(16'h1000, CSUM_BYTES, payload_xor());
    begin_session();
    send_frame(1'b0, 1'b0);
    wait_idle();
    check_end("full", 4096, 1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Payload XOR of the two-word frame is 0x22, so a 0x00 trailer must fail after both writes.
    exp_words = '{32'hDEADBEEF, 32'h01234567};
    make_frame(16'd2, 1, 8'h00);
    begin_session();
    send_frame(1'b0, 1'b0);
    wait_idle();
    check_end("csum_bad", 2, 0, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
